uart_sram_transmitter: RTL and testbench

Streams a contiguous region of external SRAM out of the board over the UART TX pin. It is the transmit counterpart of the UART receive path that loads the compressed image into SRAM. The top-level FSM grants it SRAM and the UART_TX_O pin during a dedicated dump state, typically after decoding, to return the decoded RGB segment to the host. It issues SRAM reads only, never writes. Each 16-bit word goes out as two 8N1 frames, high byte first.

---
 rtl/uart_sram_transmitter.sv | 149 ++++++++++++++
 tb/tb_uart_sram_transmitter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_sram_transmitter.sv
// uart_sram_transmitter: streams a contiguous SRAM word range out as 8N1 UART frames, high byte first.
module uart_sram_transmitter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        start,
  input  logic [17:0] base_address,
  input  logic [17:0] word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [15:0] SRAM_write_data,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        busy,
  output logic        done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] S_TX_IDLE   = 3'd0;
  localparam logic [2:0] S_TX_FETCH0 = 3'd1;
  localparam logic [2:0] S_TX_FETCH1 = 3'd2;
  localparam logic [2:0] S_TX_FETCH2 = 3'd3;
  localparam logic [2:0] S_TX_START  = 3'd4;
  localparam logic [2:0] S_TX_DATA   = 3'd5;
  localparam logic [2:0] S_TX_STOP   = 3'd6;
  localparam logic [2:0] S_TX_DONE   = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [17:0]   addr_q, addr_d;
  logic [17:0]   words_q, words_d;
  logic [15:0]   word_q, word_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_sel_q, byte_sel_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          hold_q, hold_d;
  logic          tick;
  logic [7:0]    cur_byte;

  assign tick            = cnt_q == LAST;
  assign cur_byte        = byte_sel_q ? word_q[7:0] : word_q[15:8];
  assign SRAM_address    = addr_q;
  assign SRAM_we_n       = 1'b1;
  assign SRAM_write_data = 16'd0;
  assign UART_TX_O       = tx_q;
  assign busy            = busy_q;
  assign done            = done_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    words_d    = words_q;
    word_d     = word_q;
    shift_d    = shift_q;
    byte_sel_d = byte_sel_q;
    bit_d      = bit_q;
    cnt_d      = (state_q == S_TX_START || state_q == S_TX_DATA || state_q == S_TX_STOP)
                 ? (tick ? '0 : cnt_q + BW'(1)) : cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hold_d     = hold_q;
    case (state_q)
      S_TX_IDLE: if (start) begin
        addr_d  = base_address;
        words_d = word_count;
        cnt_d   = '0;
        busy_d  = word_count != 18'd0;
        hold_d  = word_count == 18'd0;
        state_d = word_count == 18'd0 ? S_TX_DONE : S_TX_FETCH0;
      end
      S_TX_FETCH0: state_d = S_TX_FETCH1;
      S_TX_FETCH1: state_d = S_TX_FETCH2;
      S_TX_FETCH2: begin
        word_d     = SRAM_read_data;
        byte_sel_d = 1'b0;
        tx_d       = 1'b0;
        cnt_d      = '0;
        state_d    = S_TX_START;
      end
      S_TX_START: if (tick) begin
        shift_d = cur_byte;
        tx_d    = cur_byte[0];
        bit_d   = 3'd0;
        state_d = S_TX_DATA;
      end
      S_TX_DATA: if (tick) begin
        bit_d   = bit_q + 3'd1;
        shift_d = shift_q >> 1;
        tx_d    = bit_q == 3'd7 ? 1'b1 : shift_q[1];
        state_d = bit_q == 3'd7 ? S_TX_STOP : S_TX_DATA;
      end
      S_TX_STOP: if (tick) begin
        if (!byte_sel_q) begin
          byte_sel_d = 1'b1;
          tx_d       = 1'b0;
          state_d    = S_TX_START;
        end else if (words_q > 18'd1) begin
          words_d = words_q - 18'd1;
          addr_d  = addr_q + 18'd1;
          state_d = S_TX_FETCH0;
        end else begin
          state_d = S_TX_DONE;
        end
      end
      default: begin
        // a zero-length request lingers one extra cycle here before done
        hold_d  = 1'b0;
        done_d  = !hold_q;
        busy_d  = hold_q ? busy_q : 1'b0;
        state_d = hold_q ? S_TX_DONE : S_TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_TX_IDLE;
      addr_q     <= '0;
      words_q    <= '0;
      word_q     <= '0;
      shift_q    <= '0;
      byte_sel_q <= 1'b0;
      bit_q      <= '0;
      cnt_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      word_q     <= word_d;
      shift_q    <= shift_d;
      byte_sel_q <= byte_sel_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hold_q     <= hold_d;
    end
  end
endmodule

// File: tb/tb_uart_sram_transmitter.sv
// tb_uart_sram_transmitter: scoreboard bench; a UART line decoder and a done monitor check against queued expectations.
module tb_uart_sram_transmitter;
  localparam int C = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [17:0] base_address = '0;
  logic [17:0] word_count = '0;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_write_data;
  logic [15:0] rd = '0;
  logic        UART_TX_O;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  uart_sram_transmitter #(.CLKS_PER_BIT(C)) dut (
    .CLOCK_50_I(clk), .resetn(resetn), .start(start),
    .base_address(base_address), .word_count(word_count),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n),
    .SRAM_write_data(SRAM_write_data), .SRAM_read_data(rd),
    .UART_TX_O(UART_TX_O), .busy(busy), .done(done)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM with a two-register read path: data is stable by the third edge after an address change
  logic [15:0] mem [int];
  logic [15:0] salt = 16'h0;
  logic [17:0] a1 = '0;
  function automatic logic [15:0] mem_val(logic [17:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : (a[15:0] ^ salt);
  endfunction
  always @(posedge clk) begin
    a1 <= SRAM_address;
    rd <= mem_val(a1);
  end

  int tests = 0;
  int fails = 0;
  byte unsigned exp_bytes[$];
  int unsigned  exp_done[$];
  logic [17:0]  exp_addr = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && done) begin
      if (exp_done.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        check("done_cycle", cyc, exp_done.pop_front());
        check("end_addr", SRAM_address, exp_addr);
        check("busy_at_done", busy, 0);
      end
    end
  end

  logic ab;
  task automatic wait_n(int n);
    repeat (n) begin
      @(negedge clk);
      if (!resetn) ab = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (resetn && !UART_TX_O) begin
        logic [7:0] b;
        logic       fr;
        ab = 1'b0;
        wait_n(C / 2);
        fr = !UART_TX_O;
        for (int i = 0; i < 8; i++) begin
          wait_n(C);
          b[i] = UART_TX_O;
        end
        wait_n(C);
        fr = fr & UART_TX_O;
        if (!ab) begin
          check("frame_bits", fr, 1);
          if (exp_bytes.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got %02h expected none", b);
          end else check("byte", b, exp_bytes.pop_front());
        end
      end
    end
  end

  task automatic xfer(logic [17:0] b, logic [17:0] n);
    logic [15:0] w;
    @(negedge clk);
    start = 1'b1;
    base_address = b;
    word_count = n;
    @(negedge clk);
    start = 1'b0;
    base_address = 18'($urandom);
    word_count = 18'($urandom);
    for (int i = 0; i < int'(n); i++) begin
      w = mem_val(b + 18'(i));
      exp_bytes.push_back(w[15:8]);
      exp_bytes.push_back(w[7:0]);
    end
    exp_done.push_back(n == 0 ? cyc + 2 : cyc + int'(n) * (20 * C + 3) + 1);
    exp_addr = n == 0 ? b : b + n - 18'd1;
    check("busy_after_start", busy, n != 0);
    check("addr_latched", SRAM_address, b);
  endtask

  task automatic wait_done();
    int k = 0;
    while ((exp_done.size() != 0 || exp_bytes.size() != 0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("complete_in_time", k < 5000, 1);
  endtask

  initial begin
    logic        ok;
    logic [17:0] b;
    repeat (3) @(negedge clk);
    check("rst_tx", UART_TX_O, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", SRAM_address, 0);
    check("we_n", SRAM_we_n, 1);
    check("wdata", SRAM_write_data, 0);
    resetn = 1'b1;
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!UART_TX_O || busy || done || SRAM_address != 0 || !SRAM_we_n) ok = 1'b0;
    end
    check("idle_100", ok, 1);

    mem[32'h100] = 16'hA55A;
    xfer(18'h100, 18'd1);
    wait_done();

    mem[32'h3FFFF] = 16'h1234;
    mem[0] = 16'hBEEF;
    xfer(18'h3FFFF, 18'd2);
    wait_done();

    xfer(18'h155, 18'd0);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (busy || !UART_TX_O) ok = 1'b0;
    end
    check("zero_quiet", ok, 1);
    wait_done();

    salt = 16'($urandom);
    xfer(18'h2000, 18'd2);
    repeat (20 * C + 3 + 5) @(negedge clk);
    start = 1'b1;
    base_address = 18'h777;
    word_count = 18'd3;
    @(negedge clk);
    start = 1'b0;
    check("busy_held", busy, 1);
    wait_done();

    for (int t = 0; t < 8; t++) begin
      salt = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 18'h3FFFF - 18'($urandom_range(0, 2)) : 18'($urandom);
      xfer(b, 18'($urandom_range(1, 3)));
      wait_done();
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    mem[32'h2A0] = 16'h3C96;
    mem[32'h2A1] = 16'h81E7;
    xfer(18'h2A0, 18'd2);
    repeat (3 + C + 1) @(negedge clk);
    #2 resetn = 1'b0;
    exp_bytes.delete();
    exp_done.delete();
    #1;
    check("async_rst_tx", UART_TX_O, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_addr", SRAM_address, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (12 * C) @(negedge clk);
    check("post_rst_tx", UART_TX_O, 1);
    xfer(18'h2A0, 18'd2);
    wait_done();
    repeat (20) @(negedge clk);
    check("queues_empty", exp_bytes.size() + exp_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
